// File: rtl/simple_ppu_bridge_router.sv
// Bridge-side transaction router: decodes each bridge access into one of NUM_CH
// address windows, strobes the selected target and waits for its ack, bounded by a timeout.
module simple_ppu_bridge_router #(
  parameter int                   NUM_CH     = 4,
  parameter int                   DATA_W     = 32,
  parameter logic [NUM_CH*32-1:0] CH_BASE    = {32'h50000000, 32'hF8000000, 32'h40000000, 32'h00000000},
  parameter logic [NUM_CH*32-1:0] CH_MASK    = {32'h00000000, 32'h00FFFFFF, 32'h0000FFFF, 32'h03FFFFFF},
  parameter int                   TIMEOUT    = 255,
  parameter logic [DATA_W-1:0]    DEFAULT_RD = '0,
  parameter logic [DATA_W-1:0]    TIMEOUT_RD = 32'hDEADBEEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              bridge_addr,
  input  logic                     bridge_rd,
  input  logic                     bridge_wr,
  input  logic [DATA_W-1:0]        bridge_wr_data,
  output logic [DATA_W-1:0]        bridge_rd_data,
  output logic                     busy,
  output logic [NUM_CH-1:0]        ch_rd,
  output logic [NUM_CH-1:0]        ch_wr,
  output logic [31:0]              ch_addr,
  output logic [DATA_W-1:0]        ch_wr_data,
  input  logic [NUM_CH*DATA_W-1:0] ch_rd_data,
  input  logic [NUM_CH-1:0]        ch_ack,
  output logic [15:0]              err_unmapped,
  output logic [15:0]              err_timeout,
  output logic [15:0]              err_overrun,
  output logic [31:0]              last_err_addr
);

  localparam int         SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t            state, state_d;
  logic [SEL_W-1:0]  sel, dec_sel;
  logic              hit;
  logic [31:0]       dec_mask;
  logic              op_wr;
  logic [31:0]       lat_addr;
  logic [7:0]        to_cnt;
  logic [NUM_CH-1:0] sel_oh;
  logic              req, ack_sel;
  logic              accept, ack_done, to_done, overrun, unmapped;
  logic [DATA_W-1:0] sel_rd_data;

  // Requests are single-cycle pulses sampled only in IDLE; a target completes by
  // raising its own ch_ack bit with ch_rd_data valid in that same cycle.
  assign req         = bridge_rd | bridge_wr;
  assign ack_sel     = ch_ack[sel];
  assign sel_rd_data = ch_rd_data[DATA_W*sel +: DATA_W];
  assign busy        = (state != IDLE);
  assign ch_rd       = (state == ISSUE && !op_wr) ? sel_oh : '0;
  assign ch_wr       = (state == ISSUE &&  op_wr) ? sel_oh : '0;

  // Walk downwards so the lowest matching window is the one left standing.
  always_comb begin
    hit      = 1'b0;
    dec_sel  = '0;
    dec_mask = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ((bridge_addr & ~CH_MASK[32*i +: 32]) == (CH_BASE[32*i +: 32] & ~CH_MASK[32*i +: 32])) begin
        hit      = 1'b1;
        dec_sel  = i[SEL_W-1:0];
        dec_mask = CH_MASK[32*i +: 32];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sel_oh[i] = (sel == i[SEL_W-1:0]);
    end
  end

  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    ack_done = 1'b0;
    to_done  = 1'b0;
    overrun  = 1'b0;
    unmapped = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          overrun = bridge_rd & bridge_wr;
          if (hit) begin
            accept  = 1'b1;
            state_d = ISSUE;
          end else begin
            unmapped = 1'b1;
          end
        end
      end
      ISSUE: begin
        overrun = req;
        if (ack_sel) begin
          ack_done = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        overrun = req;
        if (ack_sel) begin
          ack_done = 1'b1;
          state_d  = IDLE;
        end else if ((to_cnt + 8'd1) == TO_LIM) begin
          to_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      sel            <= '0;
      op_wr          <= 1'b0;
      lat_addr       <= '0;
      ch_addr        <= '0;
      ch_wr_data     <= '0;
      to_cnt         <= '0;
      bridge_rd_data <= '0;
      err_unmapped   <= '0;
      err_timeout    <= '0;
      err_overrun    <= '0;
      last_err_addr  <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        sel        <= dec_sel;
        op_wr      <= bridge_wr;
        lat_addr   <= bridge_addr;
        ch_addr    <= bridge_addr & dec_mask;
        ch_wr_data <= bridge_wr_data;
      end
      if (state == ISSUE) begin
        to_cnt <= '0;
      end else if (state == WAIT) begin
        to_cnt <= to_cnt + 8'd1;
      end
      if (ack_done && !op_wr) begin
        bridge_rd_data <= sel_rd_data;
      end else if (to_done && !op_wr) begin
        bridge_rd_data <= TIMEOUT_RD;
      end else if (unmapped && !bridge_wr) begin
        bridge_rd_data <= DEFAULT_RD;
      end
      if (unmapped && err_unmapped != 16'hFFFF) err_unmapped <= err_unmapped + 16'd1;
      if (to_done  && err_timeout  != 16'hFFFF) err_timeout  <= err_timeout  + 16'd1;
      if (overrun  && err_overrun  != 16'hFFFF) err_overrun  <= err_overrun  + 16'd1;
      // A dropped request is newer than the transaction timing out under it.
      if (overrun || unmapped) begin
        last_err_addr <= bridge_addr;
      end else if (to_done) begin
        last_err_addr <= lat_addr;
      end
    end
  end

endmodule

// File: tb/tb_simple_ppu_bridge_router.sv
// Bench for simple_ppu_bridge_router: transaction-timeline model, per-cycle compare,
// directed scenarios with literal pins, then randomized traffic.
module tb_simple_ppu_bridge_router;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [31:0]              bridge_addr = '0;
  logic                     bridge_rd = 1'b0;
  logic                     bridge_wr = 1'b0;
  logic [DATA_W-1:0]        bridge_wr_data = '0;
  logic [DATA_W-1:0]        bridge_rd_data;
  logic                     busy;
  logic [NUM_CH-1:0]        ch_rd, ch_wr;
  logic [31:0]              ch_addr;
  logic [DATA_W-1:0]        ch_wr_data;
  logic [NUM_CH*DATA_W-1:0] ch_rd_data = '0;
  logic [NUM_CH-1:0]        ch_ack = '0;
  logic [15:0]              err_unmapped, err_timeout, err_overrun;
  logic [31:0]              last_err_addr;

  // clock / reset
  always #5 clk = ~clk;

  simple_ppu_bridge_router dut (
    .clk(clk), .reset(reset),
    .bridge_addr(bridge_addr), .bridge_rd(bridge_rd), .bridge_wr(bridge_wr),
    .bridge_wr_data(bridge_wr_data), .bridge_rd_data(bridge_rd_data), .busy(busy),
    .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_wr_data(ch_wr_data),
    .ch_rd_data(ch_rd_data), .ch_ack(ch_ack),
    .err_unmapped(err_unmapped), .err_timeout(err_timeout), .err_overrun(err_overrun),
    .last_err_addr(last_err_addr)
  );

  // window map, listed by channel index
  logic [31:0] base_a [NUM_CH] = '{32'h00000000, 32'h40000000, 32'hF8000000, 32'h50000000};
  logic [31:0] mask_a [NUM_CH] = '{32'h03FFFFFF, 32'h0000FFFF, 32'h00FFFFFF, 32'h00000000};

  int n_cmp = 0;
  int n_fail = 0;

  // model: one in-flight transaction described by its issue and completion cycles
  int          cyc = 0;
  bit          model_valid = 0;
  bit          m_active = 0;
  int          m_issue = 0, m_done = 0, m_ch = 0;
  bit          m_wr = 0, m_ack = 0;
  logic [31:0] m_addr = '0, m_ackdat = '0;
  int          ack_cyc = -1, ack_ch = 0;
  logic [31:0] ack_dat = '0;
  int          p_lat = -1;
  logic [31:0] p_dat = '0;

  bit          exp_busy = 0, exp_chk_lat = 0, rd_ret_now = 0;
  logic [3:0]  exp_ch_rd = '0, exp_ch_wr = '0;
  logic [31:0] exp_ch_addr = '0, exp_wd = '0, exp_rd = '0, exp_last = '0;
  logic [15:0] exp_un = '0, exp_to = '0, exp_ov = '0;
  logic [31:0] exp_q[$];

  function automatic int decode(input logic [31:0] a);
    for (int c = 0; c < NUM_CH; c++) begin
      if ((a & ~mask_a[c]) == (base_a[c] & ~mask_a[c])) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit ov, um, to;
    int ch;
    ov = 0; um = 0; to = 0; rd_ret_now = 0;
    if (reset) begin
      m_active = 0;
      exp_rd = '0; exp_un = '0; exp_to = '0; exp_ov = '0; exp_last = '0;
      exp_ch_addr = '0; exp_wd = '0;
      exp_q.delete();
    end else begin
      if (m_active) begin
        if (bridge_rd || bridge_wr) ov = 1;
        if (cyc == m_done) begin
          if (!m_wr) begin
            exp_rd = m_ack ? m_ackdat : 32'hDEADBEEF;
            exp_q.push_back(exp_rd);
            rd_ret_now = 1;
          end
          to = !m_ack;
          m_active = 0;
        end
      end else if (bridge_rd || bridge_wr) begin
        ov = bridge_rd && bridge_wr;
        ch = decode(bridge_addr);
        if (ch < 0) begin
          um = 1;
          if (!bridge_wr) begin
            exp_rd = 32'h0;
            exp_q.push_back(exp_rd);
            rd_ret_now = 1;
          end
        end else begin
          m_active    = 1;
          m_ch        = ch;
          m_wr        = bridge_wr;
          m_addr      = bridge_addr;
          m_issue     = cyc + 1;
          exp_ch_addr = bridge_addr & mask_a[ch];
          exp_wd      = bridge_wr_data;
          m_ack       = (p_lat >= 0 && p_lat <= 255);
          m_done      = m_issue + (m_ack ? p_lat : 255);
          m_ackdat    = p_dat;
          if (p_lat >= 0) begin
            ack_cyc = m_issue + p_lat;
            ack_ch  = ch;
            ack_dat = p_dat;
          end else begin
            ack_cyc = -1;
          end
        end
      end
      if (um) exp_un = sat16(exp_un);
      if (to) exp_to = sat16(exp_to);
      if (ov) exp_ov = sat16(exp_ov);
      if (ov || um) exp_last = bridge_addr;
      else if (to) exp_last = m_addr;
    end
    cyc++;
    exp_busy    = m_active;
    exp_ch_rd   = (m_active && cyc == m_issue && !m_wr) ? (4'b0001 << m_ch) : 4'b0000;
    exp_ch_wr   = (m_active && cyc == m_issue &&  m_wr) ? (4'b0001 << m_ch) : 4'b0000;
    exp_chk_lat = m_active || reset;
    model_valid = 1;
  endtask

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk) begin
    if (model_valid) begin
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("ch_rd", {28'b0, ch_rd}, {28'b0, exp_ch_rd});
      chk("ch_wr", {28'b0, ch_wr}, {28'b0, exp_ch_wr});
      chk("bridge_rd_data", bridge_rd_data, exp_rd);
      chk("err_unmapped", {16'b0, err_unmapped}, {16'b0, exp_un});
      chk("err_timeout", {16'b0, err_timeout}, {16'b0, exp_to});
      chk("err_overrun", {16'b0, err_overrun}, {16'b0, exp_ov});
      chk("last_err_addr", last_err_addr, exp_last);
      if (exp_chk_lat) begin
        chk("ch_addr", ch_addr, exp_ch_addr);
        chk("ch_wr_data", ch_wr_data, exp_wd);
      end
      if (rd_ret_now && exp_q.size() > 0) chk("rd_return", bridge_rd_data, exp_q.pop_front());
    end
  end

  // drivers
  task automatic drive_ack();
    ch_ack = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_rd_data[32*c +: 32] = $urandom;
      if (!(m_active && c == m_ch) && !(ack_cyc >= cyc && c == ack_ch) && $urandom_range(0, 7) == 0)
        ch_ack[c] = 1'b1;
    end
    if (cyc == ack_cyc) begin
      ch_ack[ack_ch] = 1'b1;
      ch_rd_data[32*ack_ch +: 32] = ack_dat;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    bridge_rd = 1'b0;
    bridge_wr = 1'b0;
    p_lat     = -1;
    drive_ack();
  endtask

  task automatic req(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] d,
                     input int lat, input logic [31:0] ackd);
    bridge_addr    = a;
    bridge_rd      = rd;
    bridge_wr      = wr;
    bridge_wr_data = d;
    p_lat          = lat;
    p_dat          = ackd;
    tick();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_active && n < 400) begin
      tick();
      n++;
    end
    if (m_active) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idle: transaction still open after %0d cycles", n);
    end
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r, lat;
    bit rd, wr;

    // reset
    ticks(3);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_rd_data", bridge_rd_data, 32'h0);
    chk("reset_last_err", last_err_addr, 32'h0);

    // read ch3, ack two cycles after the strobe
    req(32'h50000000, 1, 0, 32'h0, 2, 32'h12345678);
    @(negedge clk);
    chk("rd3_strobe", {28'b0, ch_rd}, 32'h8);
    chk("rd3_addr", ch_addr, 32'h0);
    wait_idle();
    @(negedge clk);
    chk("rd3_data", bridge_rd_data, 32'h12345678);
    chk("rd3_no_err", {16'b0, err_unmapped}, 32'd0);

    // write ch2
    req(32'hF8001234, 0, 1, 32'hCAFEF00D, 1, 32'h0);
    @(negedge clk);
    chk("wr2_strobe", {28'b0, ch_wr}, 32'h4);
    chk("wr2_addr", ch_addr, 32'h00001234);
    chk("wr2_data", ch_wr_data, 32'hCAFEF00D);
    wait_idle();
    @(negedge clk);
    chk("wr2_rd_data_kept", bridge_rd_data, 32'h12345678);

    // unmapped read
    req(32'h60000000, 1, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("unmap_busy", {31'b0, busy}, 32'd0);
    chk("unmap_rd_data", bridge_rd_data, 32'h0);
    chk("unmap_count", {16'b0, err_unmapped}, 32'd1);
    chk("unmap_last", last_err_addr, 32'h60000000);

    // timeout on ch1, ack shows up long after
    req(32'h40000010, 1, 0, 32'h0, 300, 32'h11112222);
    wait_idle();
    @(negedge clk);
    chk("to_rd_data", bridge_rd_data, 32'hDEADBEEF);
    chk("to_count", {16'b0, err_timeout}, 32'd1);
    chk("to_last", last_err_addr, 32'h40000010);
    ticks(60);
    @(negedge clk);
    chk("late_ack_ignored", bridge_rd_data, 32'hDEADBEEF);

    // request dropped while waiting
    req(32'h40000020, 1, 0, 32'h0, 8, 32'h0BADCAFE);
    ticks(2);
    req(32'h00000004, 1, 0, 32'h0, 0, 32'h0);
    wait_idle();
    @(negedge clk);
    chk("ovr_count", {16'b0, err_overrun}, 32'd1);
    chk("ovr_last", last_err_addr, 32'h00000004);
    chk("ovr_orig_data", bridge_rd_data, 32'h0BADCAFE);

    // reset in the middle of WAIT
    req(32'h50000000, 1, 0, 32'h0, 10, 32'h77778888);
    ticks(3);
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_rd_data", bridge_rd_data, 32'h0);
    chk("rst_mid_overrun", {16'b0, err_overrun}, 32'd0);
    ticks(15);
    req(32'h00000000, 1, 0, 32'h0, 3, 32'hA5A5A5A5);
    wait_idle();
    @(negedge clk);
    chk("post_rst_data", bridge_rd_data, 32'hA5A5A5A5);
    chk("post_rst_timeout", {16'b0, err_timeout}, 32'd0);
    chk("post_rst_unmapped", {16'b0, err_unmapped}, 32'd0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2: a = $urandom & 32'h03FFFFFF;
          3, 4:    a = 32'h40000000 | ($urandom & 32'h0000FFFF);
          5, 6:    a = 32'hF8000000 | ($urandom & 32'h00FFFFFF);
          7:       a = 32'h50000000;
          8:       a = 32'h60000000 | ($urandom & 32'h0000FFFF);
          default: a = 32'h50000000 | (32'($urandom_range(1, 255)) << 4);
        endcase
        r = $urandom_range(0, 9);
        rd = (r == 0) || (r > 4);
        wr = (r <= 4);
        r = $urandom_range(0, 99);
        if (r < 85)      lat = $urandom_range(0, 6);
        else if (r < 97) lat = $urandom_range(7, 40);
        else             lat = -1;
        req(a, rd, wr, $urandom, lat, $urandom);
      end else begin
        tick();
      end
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
